// File: rtl/fetch_buffered.sv
// N-wide fetch front end: aligned block requests to imem, in-order bundle buffer toward decode.
// Define FETCH_BUFFERED_PERF_EN to add saturating performance counters.
module fetch_buffered #(
   parameter int unsigned     XLEN            = 32,
   parameter int unsigned     FETCH_WIDTH     = 2,
   parameter int unsigned     FBUF_DEPTH      = 4,
   parameter int unsigned     MAX_OUTSTANDING = 4,
   parameter logic [XLEN-1:0] RESET_PC        = '0
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        fetch_en,
   input  logic                        redirect_en,
   input  logic [XLEN-1:0]             redirect_pc,
   output logic                        imem_req_valid,
   input  logic                        imem_req_ready,
   output logic [XLEN-1:0]             imem_req_addr,
   input  logic                        imem_resp_valid,
   input  logic [FETCH_WIDTH*XLEN-1:0] imem_resp_data,
   output logic                        fb_valid,
   input  logic                        fb_ready,
   output logic [FETCH_WIDTH-1:0]      fb_mask,
   output logic [FETCH_WIDTH*XLEN-1:0] fb_pc,
   output logic [FETCH_WIDTH*XLEN-1:0] fb_instr
`ifdef FETCH_BUFFERED_PERF_EN
   ,
   output logic [31:0]                 perf_fbuf_full_cycles,
   output logic [31:0]                 perf_dropped_resp,
   output logic [31:0]                 perf_bundles_out
`endif
);

   localparam int unsigned BW    = FETCH_WIDTH * XLEN;
   localparam int unsigned BLOCK = FETCH_WIDTH * 4;
   localparam int unsigned OCW   = $clog2(FBUF_DEPTH + 1);
   localparam int unsigned OUW   = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned FPW   = (FBUF_DEPTH > 1) ? $clog2(FBUF_DEPTH) : 1;
   localparam int unsigned PPW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int unsigned SW    = ((OCW > OUW) ? OCW : OUW) + 1;

   logic [XLEN-1:0]        pc_q, pc_d;
   logic [OCW-1:0]         occ_q, occ_d;
   logic [OUW-1:0]         out_q, out_d;
   logic [OUW-1:0]         drop_q, drop_d;
   logic [PPW-1:0]         pq_rd_q, pq_rd_d, pq_wr_q, pq_wr_d;
   logic [FPW-1:0]         buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
   logic [XLEN-1:0]        pq_addr_q [MAX_OUTSTANDING];
   logic [XLEN-1:0]        pq_addr_d [MAX_OUTSTANDING];
   logic [FETCH_WIDTH-1:0] pq_mask_q [MAX_OUTSTANDING];
   logic [FETCH_WIDTH-1:0] pq_mask_d [MAX_OUTSTANDING];
   logic [XLEN-1:0]        buf_addr_q [FBUF_DEPTH];
   logic [XLEN-1:0]        buf_addr_d [FBUF_DEPTH];
   logic [FETCH_WIDTH-1:0] buf_mask_q [FBUF_DEPTH];
   logic [FETCH_WIDTH-1:0] buf_mask_d [FBUF_DEPTH];
   logic [BW-1:0]          buf_data_q [FBUF_DEPTH];
   logic [BW-1:0]          buf_data_d [FBUF_DEPTH];

   logic [XLEN-1:0]        aligned_pc, start_slot;
   logic [FETCH_WIDTH-1:0] req_mask;
   logic                   credit_ok, room_ok, req_fire, resp_ok, resp_drop, buf_push, buf_pop;

   function automatic logic [PPW-1:0] pq_inc(input logic [PPW-1:0] p);
      return (p == PPW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [FPW-1:0] buf_inc(input logic [FPW-1:0] p);
      return (p == FPW'(FBUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign fb_valid = (occ_q != '0);

   always_comb begin
      aligned_pc = pc_q & ~XLEN'(BLOCK - 1);
      start_slot = (pc_q >> 2) & XLEN'(FETCH_WIDTH - 1);
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         req_mask[i] = (XLEN'(i) >= start_slot);
      end
      // Counting outstanding requests against buffer space means every response has a slot.
      credit_ok      = (SW'(occ_q) + SW'(out_q)) < SW'(FBUF_DEPTH);
      room_ok        = out_q < OUW'(MAX_OUTSTANDING);
      imem_req_valid = ~reset & fetch_en & ~redirect_en & credit_ok & room_ok;
      imem_req_addr  = aligned_pc;
      req_fire       = imem_req_valid & imem_req_ready;
      resp_ok        = imem_resp_valid & (out_q != '0);
      resp_drop      = resp_ok & (redirect_en | (drop_q != '0));
      buf_push       = resp_ok & ~resp_drop;
      buf_pop        = fb_valid & fb_ready & ~redirect_en;
   end

   always_comb begin
      pc_d       = pc_q;
      occ_d      = occ_q;
      drop_d     = drop_q;
      pq_rd_d    = pq_rd_q;
      pq_wr_d    = pq_wr_q;
      buf_rd_d   = buf_rd_q;
      buf_wr_d   = buf_wr_q;
      pq_addr_d  = pq_addr_q;
      pq_mask_d  = pq_mask_q;
      buf_addr_d = buf_addr_q;
      buf_mask_d = buf_mask_q;
      buf_data_d = buf_data_q;
      out_d      = out_q + OUW'(req_fire) - OUW'(resp_ok);

      if (req_fire) begin
         pq_addr_d[pq_wr_q] = aligned_pc;
         pq_mask_d[pq_wr_q] = req_mask;
         pq_wr_d            = pq_inc(pq_wr_q);
         pc_d               = aligned_pc + XLEN'(BLOCK);
      end
      if (resp_ok) begin
         pq_rd_d = pq_inc(pq_rd_q);
      end

      if (redirect_en) begin
         // Everything still in flight after this cycle belongs to the old path.
         pc_d     = redirect_pc;
         occ_d    = '0;
         buf_rd_d = '0;
         buf_wr_d = '0;
         drop_d   = out_q - OUW'(resp_ok);
      end else begin
         if (resp_drop) begin
            drop_d = drop_q - 1'b1;
         end
         if (buf_push) begin
            buf_addr_d[buf_wr_q] = pq_addr_q[pq_rd_q];
            buf_mask_d[buf_wr_q] = pq_mask_q[pq_rd_q];
            buf_data_d[buf_wr_q] = imem_resp_data;
            buf_wr_d             = buf_inc(buf_wr_q);
         end
         if (buf_pop) begin
            buf_rd_d = buf_inc(buf_rd_q);
         end
         occ_d = occ_q + OCW'(buf_push) - OCW'(buf_pop);
      end
   end

   always_comb begin
      fb_mask  = '0;
      fb_pc    = '0;
      fb_instr = '0;
      if (fb_valid) begin
         fb_mask  = buf_mask_q[buf_rd_q];
         fb_instr = buf_data_q[buf_rd_q];
         for (int i = 0; i < FETCH_WIDTH; i++) begin
            fb_pc[i*XLEN +: XLEN] = buf_addr_q[buf_rd_q] + XLEN'(4 * i);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q     <= RESET_PC;
         occ_q    <= '0;
         out_q    <= '0;
         drop_q   <= '0;
         pq_rd_q  <= '0;
         pq_wr_q  <= '0;
         buf_rd_q <= '0;
         buf_wr_q <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            pq_addr_q[i] <= '0;
            pq_mask_q[i] <= '0;
         end
         for (int i = 0; i < FBUF_DEPTH; i++) begin
            buf_addr_q[i] <= '0;
            buf_mask_q[i] <= '0;
            buf_data_q[i] <= '0;
         end
      end else begin
         pc_q       <= pc_d;
         occ_q      <= occ_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
         pq_rd_q    <= pq_rd_d;
         pq_wr_q    <= pq_wr_d;
         buf_rd_q   <= buf_rd_d;
         buf_wr_q   <= buf_wr_d;
         pq_addr_q  <= pq_addr_d;
         pq_mask_q  <= pq_mask_d;
         buf_addr_q <= buf_addr_d;
         buf_mask_q <= buf_mask_d;
         buf_data_q <= buf_data_d;
      end
   end

`ifdef FETCH_BUFFERED_PERF_EN
   logic [31:0] perf_full_q, perf_full_d, perf_drop_q, perf_drop_d, perf_out_q, perf_out_d;
   logic        full_block;

   always_comb begin
      full_block  = fetch_en & ~redirect_en & room_ok & ~credit_ok;
      perf_full_d = perf_full_q + 32'((full_block && perf_full_q != '1) ? 1 : 0);
      perf_drop_d = perf_drop_q + 32'((resp_drop && perf_drop_q != '1) ? 1 : 0);
      perf_out_d  = perf_out_q + 32'((buf_pop && perf_out_q != '1) ? 1 : 0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_full_q <= '0;
         perf_drop_q <= '0;
         perf_out_q  <= '0;
      end else begin
         perf_full_q <= perf_full_d;
         perf_drop_q <= perf_drop_d;
         perf_out_q  <= perf_out_d;
      end
   end

   assign perf_fbuf_full_cycles = perf_full_q;
   assign perf_dropped_resp     = perf_drop_q;
   assign perf_bundles_out      = perf_out_q;
`endif

`ifndef SYNTHESIS
   resp_without_request: assert property (@(posedge clk) disable iff (reset)
      !(imem_resp_valid && out_q == '0))
      else $error("imem response with no request outstanding");
`endif

endmodule

// File: tb/tb_fetch_buffered.sv
// Bench for fetch_buffered: queue-based reference model, randomized traffic, directed redirect cases.
// A second instance (FETCH_WIDTH=4, FBUF_DEPTH=8) covers the misaligned wide-redirect case.
module tb_fetch_buffered;
   localparam int FW = 2;
   localparam int FD = 4;
   localparam int MO = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_en = 1'b0, redirect_en = 1'b0, imem_req_ready = 1'b0, imem_resp_valid = 1'b0;
   logic        fb_ready = 1'b0, imem_req_valid, fb_valid;
   logic [31:0] redirect_pc = '0, imem_req_addr;
   logic [63:0] imem_resp_data = '0, fb_pc, fb_instr;
   logic [1:0]  fb_mask;

   logic         fetch_en2 = 1'b0, redirect_en2 = 1'b0, req_ready2 = 1'b0, resp_valid2 = 1'b0;
   logic         fb_ready2 = 1'b0, req_valid2, fb_valid2;
   logic [31:0]  redirect_pc2 = '0, req_addr2;
   logic [127:0] resp_data2 = '0, fb_pc2, fb_instr2;
   logic [3:0]   fb_mask2;

`ifdef FETCH_BUFFERED_PERF_EN
   logic [31:0] perf_full, perf_drop, perf_out, perf_full2, perf_drop2, perf_out2;
`endif

   always #5 clk = ~clk;

   fetch_buffered dut (
      .clk(clk), .reset(reset), .fetch_en(fetch_en), .redirect_en(redirect_en),
      .redirect_pc(redirect_pc), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
      .imem_resp_data(imem_resp_data), .fb_valid(fb_valid), .fb_ready(fb_ready),
      .fb_mask(fb_mask), .fb_pc(fb_pc), .fb_instr(fb_instr)
`ifdef FETCH_BUFFERED_PERF_EN
      , .perf_fbuf_full_cycles(perf_full), .perf_dropped_resp(perf_drop),
      .perf_bundles_out(perf_out)
`endif
   );

   fetch_buffered #(.FETCH_WIDTH(4), .FBUF_DEPTH(8)) dut4 (
      .clk(clk), .reset(reset), .fetch_en(fetch_en2), .redirect_en(redirect_en2),
      .redirect_pc(redirect_pc2), .imem_req_valid(req_valid2), .imem_req_ready(req_ready2),
      .imem_req_addr(req_addr2), .imem_resp_valid(resp_valid2), .imem_resp_data(resp_data2),
      .fb_valid(fb_valid2), .fb_ready(fb_ready2), .fb_mask(fb_mask2), .fb_pc(fb_pc2),
      .fb_instr(fb_instr2)
`ifdef FETCH_BUFFERED_PERF_EN
      , .perf_fbuf_full_cycles(perf_full2), .perf_dropped_resp(perf_drop2),
      .perf_bundles_out(perf_out2)
`endif
   );

   int checks = 0;
   int errors = 0;

   typedef struct { logic [31:0] addr; logic [FW-1:0] mask; bit stale; } req_t;
   typedef struct { logic [31:0] addr; logic [FW-1:0] mask; logic [63:0] data; } bun_t;
   typedef struct { logic [31:0] addr; int due; } mreq_t;

   req_t        inflight[$];
   bun_t        fbq[$];
   mreq_t       memq[$];
   logic [31:0] m_pc;
   int          m_dropped, m_full, m_out, cyc, last_due, lat, n_accepted;

   bit          s_fetch, s_redir, s_fbready, s_ready;
   logic [31:0] s_rpc;
   bit          o_req_valid, o_fb_valid, o_resp, o_accepted;
   logic [31:0] o_req_addr, o_acc_addr;
   logic [1:0]  o_fb_mask;
   logic [63:0] o_fb_pc, o_fb_instr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   function automatic logic [63:0] mem_block(input logic [31:0] a);
      return {mem_word(a + 32'd4), mem_word(a)};
   endfunction

   function automatic logic [127:0] mem_block4(input logic [31:0] a);
      return {mem_word(a + 32'd12), mem_word(a + 32'd8), mem_word(a + 32'd4), mem_word(a)};
   endfunction

   // Slots at or above the word offset inside the block are live.
   function automatic logic [FW-1:0] start_mask(input logic [31:0] pc);
      int s = int'((pc >> 2) % FW);
      return FW'(((1 << FW) - 1) - ((1 << s) - 1));
   endfunction

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      fetch_en = 1'b1;
      redirect_en = 1'b0;
      imem_req_ready = 1'b1;
      imem_resp_valid = 1'b0;
      fb_ready = 1'b0;
      #1;
      chk("rst_req_valid", imem_req_valid, 1'b0);
      chk("rst_fb_valid", fb_valid, 1'b0);
      chk("rst_fb_mask", fb_mask, 2'b00);
      chk("rst_fb_pc", fb_pc, 64'h0);
      chk("rst_fb_instr", fb_instr, 64'h0);
      @(negedge clk);
      reset = 1'b0;
      fetch_en = 1'b0;
      imem_req_ready = 1'b0;
      inflight.delete();
      fbq.delete();
      memq.delete();
      m_pc = 32'h0;
      m_dropped = 0;
      m_full = 0;
      m_out = 0;
      last_due = -1;
      n_accepted = 0;
      s_fetch = 0; s_redir = 0; s_fbready = 0; s_ready = 0; s_rpc = '0;
   endtask

   // One clock: drive inputs, compare outputs with the model, then advance the model past the edge.
   task automatic step();
      bit          exp_rv, blk;
      logic [31:0] al;
      req_t        r;
      bun_t        b;
      mreq_t       m;
      @(negedge clk);
      fetch_en = s_fetch;
      redirect_en = s_redir;
      redirect_pc = s_rpc;
      fb_ready = s_fbready;
      imem_req_ready = s_ready;
      o_resp = (memq.size() > 0) && (memq[0].due <= cyc);
      imem_resp_valid = o_resp;
      imem_resp_data = o_resp ? mem_block(memq[0].addr) : 64'h0;
      #1;
      o_req_valid = imem_req_valid;
      o_req_addr = imem_req_addr;
      o_fb_valid = fb_valid;
      o_fb_mask = fb_mask;
      o_fb_pc = fb_pc;
      o_fb_instr = fb_instr;

      exp_rv = s_fetch && !s_redir && (fbq.size() + inflight.size() < FD) && (inflight.size() < MO);
      blk = s_fetch && !s_redir && (inflight.size() < MO) && (fbq.size() + inflight.size() >= FD);
      al = m_pc & ~32'(FW * 4 - 1);
      chk("req_valid", o_req_valid, exp_rv);
      if (exp_rv) chk("req_addr", o_req_addr, al);
      chk("fb_valid", o_fb_valid, fbq.size() > 0);
      if (fbq.size() > 0 && o_fb_valid) begin
         chk("fb_mask", o_fb_mask, fbq[0].mask);
         chk("fb_pc", o_fb_pc, {fbq[0].addr + 32'd4, fbq[0].addr});
         chk("fb_instr", o_fb_instr, fbq[0].data);
      end
`ifdef FETCH_BUFFERED_PERF_EN
      chk("perf_full", perf_full, m_full);
      chk("perf_drop", perf_drop, m_dropped);
      chk("perf_out", perf_out, m_out);
`endif

      // The memory follows what the DUT actually did; the model follows the rules.
      if (o_resp) void'(memq.pop_front());
      o_accepted = o_req_valid && s_ready;
      if (o_accepted) begin
         m.addr = o_req_addr;
         m.due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
         last_due = m.due;
         memq.push_back(m);
         o_acc_addr = o_req_addr;
         n_accepted++;
      end

      if (blk) m_full++;
      if (s_redir) begin
         if (o_resp && inflight.size() > 0) begin
            void'(inflight.pop_front());
            m_dropped++;
         end
         foreach (inflight[i]) inflight[i].stale = 1'b1;
         fbq.delete();
         m_pc = s_rpc;
      end else begin
         if (fbq.size() > 0 && s_fbready) begin
            void'(fbq.pop_front());
            m_out++;
         end
         if (o_resp && inflight.size() > 0) begin
            r = inflight.pop_front();
            if (r.stale) m_dropped++;
            else begin
               b.addr = r.addr;
               b.mask = r.mask;
               b.data = mem_block(r.addr);
               fbq.push_back(b);
            end
         end
         if (exp_rv && s_ready) begin
            r.addr = al;
            r.mask = start_mask(m_pc);
            r.stale = 1'b0;
            inflight.push_back(r);
            m_pc = al + 32'(FW * 4);
         end
      end
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_fb(input string name);
      int k = 0;
      do begin
         step();
         k++;
      end while (!o_fb_valid && k < 30);
      if (!o_fb_valid) chk({name, "_timeout"}, 1'b0, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc = 0;
      lat = 1;
      do_reset();

      // Wide instance: misaligned redirect leaves only the last slot live.
      @(negedge clk);
      redirect_en2 = 1'b1; redirect_pc2 = 32'h1C; fetch_en2 = 1'b1; fb_ready2 = 1'b1; req_ready2 = 1'b1;
      #1 chk("t6_no_req_on_redirect", req_valid2, 1'b0);
      @(negedge clk);
      redirect_en2 = 1'b0;
      #1 chk("t6_req_valid", req_valid2, 1'b1);
      chk("t6_req_addr", req_addr2, 32'h10);
      @(negedge clk);
      resp_valid2 = 1'b1; resp_data2 = mem_block4(32'h10);
      #1 chk("t6_next_addr", req_addr2, 32'h20);
      @(negedge clk);
      resp_data2 = mem_block4(32'h20); fetch_en2 = 1'b0;
      #1 chk("t6_fb_valid", fb_valid2, 1'b1);
      chk("t6_fb_mask", fb_mask2, 4'b1000);
      chk("t6_fb_pc3", fb_pc2[127:96], 32'h1C);
      chk("t6_fb_instr3", fb_instr2[127:96], mem_word(32'h1C));
      @(negedge clk);
      resp_valid2 = 1'b0; resp_data2 = '0;
      #1 chk("t6_fb2_mask", fb_mask2, 4'b1111);
      chk("t6_fb2_pc0", fb_pc2[31:0], 32'h20);
      chk("t6_fb2_instr", fb_instr2, mem_block4(32'h20));
      @(negedge clk);
      fb_ready2 = 1'b0; req_ready2 = 1'b0;

      // 1-cycle memory streaming from reset.
      lat = 1; s_fetch = 1; s_fbready = 1; s_ready = 1;
      step();
      chk("t1_req0_valid", o_req_valid, 1'b1);
      chk("t1_req0_addr", o_req_addr, 32'h0);
      step();
      chk("t1_req1_addr", o_req_addr, 32'h8);
      step();
      chk("t1_fb_valid", o_fb_valid, 1'b1);
      chk("t1_fb_pc", o_fb_pc, {32'h4, 32'h0});
      chk("t1_fb_mask", o_fb_mask, 2'b11);
      chk("t1_fb_instr", o_fb_instr, {mem_word(32'h4), mem_word(32'h0)});
      chk("t1_req2_addr", o_req_addr, 32'h10);
      run(20);

      // Backpressure fills the buffer and stops requests.
      do_reset();
      lat = 1; s_fetch = 1; s_fbready = 0; s_ready = 1;
      run(12);
      chk("t2_accepted", n_accepted, 4);
      chk("t2_req_blocked", o_req_valid, 1'b0);
      chk("t2_head_pc", o_fb_pc, {32'h4, 32'h0});
      s_fbready = 1;
      begin
         int k = 0;
         do begin step(); k++; end while (!o_accepted && k < 10);
         chk("t2_resume_addr", o_acc_addr, 32'h20);
      end
      run(20);

      // Redirect with two requests in flight.
      do_reset();
      lat = 3; s_fetch = 1; s_fbready = 1; s_ready = 1;
      run(2);
      s_redir = 1; s_rpc = 32'h104;
      step();
      s_redir = 0;
      step();
      chk("t3_req_valid", o_req_valid, 1'b1);
      chk("t3_req_addr", o_req_addr, 32'h100);
      wait_fb("t3");
      chk("t3_fb_mask", o_fb_mask, 2'b10);
      chk("t3_fb_pc1", o_fb_pc[63:32], 32'h104);
      run(20);

      // Redirect coinciding with a response and a pop.
      do_reset();
      lat = 1; s_fetch = 1; s_fbready = 1; s_ready = 1;
      run(6);
      s_redir = 1; s_rpc = 32'h40;
      step();
      chk("t4_fb_valid_at_redirect", o_fb_valid, 1'b1);
      s_redir = 0;
      step();
      chk("t4_flushed", o_fb_valid, 1'b0);
      wait_fb("t4");
      chk("t4_target_pc", o_fb_pc, {32'h44, 32'h40});
      chk("t4_target_mask", o_fb_mask, 2'b11);
      run(10);

      // Back-to-back redirects with 3-cycle memory.
      do_reset();
      lat = 3; s_fetch = 1; s_fbready = 1; s_ready = 1;
      run(4);
      s_redir = 1; s_rpc = 32'h200;
      step();
      s_rpc = 32'h300;
      step();
      s_redir = 0;
      wait_fb("t5");
      chk("t5_first_pc", o_fb_pc[31:0], 32'h300);
`ifdef FETCH_BUFFERED_PERF_EN
      chk("t5_perf_dropped", perf_drop, 32'd3);
`endif
      run(20);

      // Randomized traffic, with a reset in the middle.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         s_fetch = ($urandom_range(0, 9) < 8);
         s_fbready = ($urandom_range(0, 9) < 7);
         s_ready = ($urandom_range(0, 9) < 8);
         s_redir = ($urandom_range(0, 99) < 3);
         s_rpc = ($urandom_range(0, 15) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1C))
                                              : ($urandom & 32'h0000_0FFC);
         lat = $urandom_range(1, 4);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
